// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for AND / shift-left / increment-N / 4-to-16 decode over a WIDTH-bit datapath.
// Optional ALU_SEQ_OP_COUNT_EN adds a 16-bit count of completed response handshakes (op_count).
module alu_op_sequencer #(
   parameter int WIDTH = 20,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_carry,
   output logic             resp_zero,
   output logic             busy
`ifdef ALU_SEQ_OP_COUNT_EN
   ,
   output logic [15:0]      op_count
`endif
);

   // state | meaning
   // IDLE  | waiting for a request, req_ready high
   // EXEC  | iterating the selected primitive
   // DONE  | result presented, waiting for resp_ready
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [1:0] OP_AND  = 2'd0;
   localparam logic [1:0] OP_SHL  = 2'd1;
   localparam logic [1:0] OP_INCN = 2'd2;
   localparam logic [1:0] OP_DEC  = 2'd3;

   state_t             state_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q, acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q, first_q;
   logic               req_ready_q, resp_valid_q, resp_carry_q, resp_zero_q, busy_q;
   logic [WIDTH-1:0]   resp_data_q;

   logic [WIDTH-1:0]   src, acc_d;
   logic [CNT_W-1:0]   cnt_d;
   logic               carry_d, last;

   // First iteration works from the latched operand; later ones from the accumulator.
   always_comb begin
      src     = first_q ? a_q : acc_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      last    = 1'b1;
      case (op_q)
         OP_AND: begin
            acc_d   = a_q & b_q;
            carry_d = 1'b0;
         end
         OP_SHL: begin
            if (cnt_q == '0) begin
               acc_d   = a_q;
               carry_d = 1'b0;
            end else begin
               acc_d   = {src[WIDTH-2:0], 1'b0};
               carry_d = src[WIDTH-1];
               cnt_d   = cnt_q - CNT_W'(1);
               last    = (cnt_q == CNT_W'(1));
            end
         end
         OP_INCN: begin
            if (cnt_q == '0) begin
               acc_d   = a_q;
               carry_d = 1'b0;
            end else begin
               acc_d   = src + WIDTH'(1);
               carry_d = carry_q | (&src);
               cnt_d   = cnt_q - CNT_W'(1);
               last    = (cnt_q == CNT_W'(1));
            end
         end
         OP_DEC: begin
            acc_d             = '0;
            acc_d[a_q[3:0]]   = 1'b1;
            carry_d           = 1'b0;
         end
      endcase
   end

`ifdef ALU_SEQ_OP_COUNT_EN
   logic [15:0] op_count_q;
   assign op_count = op_count_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         op_q         <= OP_AND;
         a_q          <= '0;
         b_q          <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         carry_q      <= 1'b0;
         first_q      <= 1'b0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_carry_q <= 1'b0;
         resp_zero_q  <= 1'b0;
         busy_q       <= 1'b0;
`ifdef ALU_SEQ_OP_COUNT_EN
         op_count_q   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  op_q        <= req_op;
                  a_q         <= req_a;
                  b_q         <= req_b;
                  cnt_q       <= req_b[CNT_W-1:0];
                  acc_q       <= '0;
                  carry_q     <= 1'b0;
                  first_q     <= 1'b1;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= EXEC;
               end
            end
            EXEC: begin
               acc_q   <= acc_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_d;
               first_q <= 1'b0;
               if (last) begin
                  resp_data_q  <= acc_d;
                  resp_carry_q <= carry_d;
                  resp_zero_q  <= ~|acc_d;
                  resp_valid_q <= 1'b1;
                  state_q      <= DONE;
               end
            end
            DONE: begin
               // Response data and flags are kept after the handshake.
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
`ifdef ALU_SEQ_OP_COUNT_EN
                  op_count_q   <= op_count_q + 16'd1;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_carry = resp_carry_q;
   assign resp_zero  = resp_zero_q;
   assign busy       = busy_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences the 20-bit ALU primitives: bitwise AND, single-bit shift-toward-MSB, incrementer and 4-to-16 decoder.
- Accepts one operation per valid/ready request and produces one result on a valid/ready response, with carry and zero flags.
- Iterates the shift and increment units N times for count-based ops, so a single shift/inc datapath serves multi-step requests.
- Sits between instruction issue logic and the ALU datapath.

Parameters:
- WIDTH, 20, datapath width in bits; must be >= 16.
- CNT_W, 5, width of the iteration-count field taken from b[CNT_W-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request (high only in IDLE).
- req_op  input  2  0=AND, 1=SHL, 2=INCN, 3=DEC.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B; AND mask, or count in b[CNT_W-1:0].
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  WIDTH  result.
- resp_carry  output  1  carry flag.
- resp_zero  output  1  high when resp_data == 0.
- busy  output  1  high in EXEC or DONE.

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_carry=0; resp_zero=0; busy=0.
- Reset mid-operation aborts immediately. No response is emitted for the aborted request.
- FSM states: IDLE, EXEC, DONE.
- IDLE -> EXEC when req_valid & req_ready. On that edge, latch op, a, b and cnt=b[CNT_W-1:0]. Clear the acc and carry registers.
- EXEC, AND: acc=a&b, carry=0. One cycle, then DONE.
- EXEC, DEC: acc[15:0]=one-hot of a[3:0], acc[WIDTH-1:16]=0, carry=0. One cycle, then DONE.
- EXEC, SHL: per cycle acc={acc[WIDTH-2:0],0} and carry=acc[WIDTH-1] (the bit shifted out), starting from acc=a.
  - Runs cnt cycles. Carry reflects the last iteration only.
  - cnt>=WIDTH yields acc=0. For cnt>WIDTH, carry=0.
- EXEC, INCN: per cycle acc=acc+1 (mod 2^WIDTH), starting from acc=a. Runs cnt cycles.
  - Carry is sticky: set if any iteration wraps all-ones to 0.
- cnt==0 for SHL/INCN: a single EXEC cycle with acc=a, carry=0.
- EXEC cycle count is therefore max(cnt,1) for SHL/INCN and 1 for AND/DEC.
- EXEC -> DONE after the final iteration. Register resp_data/resp_carry; resp_zero = ~|resp_data.
- resp_valid is high exactly in DONE. Outputs hold stable while resp_valid & ~resp_ready.
- DONE -> IDLE on resp_ready. resp_valid drops the next cycle; resp_data/flags retain their last value.
- Latency, accept edge to resp_valid high: 1 + EXEC cycles. AND with resp_ready tied high completes in 3 cycles per op.
- New requests are not accepted in DONE, even when resp_ready is high that cycle. req_ready rises only the cycle after the handshake (no same-cycle turnaround).
- req_* inputs are ignored outside the accept edge. Changes to them during EXEC have no effect.
- Unknown/X op is not possible: the 2-bit op fully covers all four operations.

Optional Feature:
- Macro: ALU_SEQ_OP_COUNT_EN.
- When defined: adds output op_count (16 bits).
  - Reset value 0.
  - Increments by 1 on each response handshake (resp_valid & resp_ready).
  - Wraps 0xFFFF -> 0.
- When undefined: no op_count port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then AND with a=0xF0F0F, b=0x0FF00 -> resp_data=0x00F00, carry=0, zero=0; resp_valid exactly 2 cycles after the accept edge.
- DEC with a=0x0000A -> resp_data=0x00400; DEC with a=0x0000F -> 0x08000; upper 4 bits zero.
- SHL with a=0x80001 and cnt=1 -> 0x00002, carry=1. SHL with a=0x00001, cnt=20 -> 0x00000, carry=1, zero=1. Verify 20 EXEC cycles.
- INCN with a=0xFFFFE, cnt=3 -> 0x00001, carry=1 (sticky). INCN with a=0x00005, cnt=0 -> 0x00005, carry=0, 1 EXEC cycle.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid and data stable, req_ready=0. Req_valid held high is accepted only the cycle after resp_ready rises.
- Assert rst mid-EXEC of SHL cnt=15 -> all outputs return to reset values immediately and no response appears. With ALU_SEQ_OP_COUNT_EN, op_count=0 after reset and equals 4 after four handshakes.
